// File: rtl/permutation_if.sv
// Request/response bundle for the iterative ASCON permutation core.
// The requester drives the input state, round count and start strobe;
// the core returns the registered result state.
interface permutation_if;
    logic [319:0] S;
    logic [4:0]   round;
    logic         start;
    logic [319:0] S_out;

    modport master (
        output S,
        output round,
        output start,
        input  S_out
    );

    modport slave (
        input  S,
        input  round,
        input  start,
        output S_out
    );
endinterface

// File: rtl/permutation.sv
// Iterative ASCON permutation p^N over a 320-bit state (x0..x4, 64-bit words).
// The state and N = min(round, 12) are captured on start. Round i of N uses
// constant index r = 12 - N + i. The core tracks the number of rounds still
// pending, so r is simply 12 - remaining.
// Optional build macro PERM_UNROLL2_EN: two cascaded rounds per clock. An odd
// N finishes with a single round, and N = 0 still takes one cycle.
module permutation (
    input  logic            clk,
    input  logic            rst,
    permutation_if.slave    bus
);

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } fsm_t;

    fsm_t         fsm_q, fsm_d;
    logic [319:0] state_q, state_d;
    logic [319:0] sout_q, sout_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [3:0]   rc;
    logic [319:0] rnd1;
`ifdef PERM_UNROLL2_EN
    logic [319:0] rnd2;
`endif

    function automatic logic [63:0] ror64(input logic [63:0] x, input int unsigned n);
        logic [127:0] d;
        d = {x, x} >> n;
        return d[63:0];
    endfunction

    // One ASCON round: constant addition, bitsliced S-box, linear diffusion.
    function automatic logic [319:0] round_f(input logic [319:0] s, input logic [3:0] r);
        logic [63:0] x0, x1, x2, x3, x4;
        logic [63:0] t0, t1, t2, t3, t4;
        logic [3:0]  rinv;
        rinv = 4'd15 - r;
        x0 = s[319:256];
        x1 = s[255:192];
        x2 = s[191:128];
        x3 = s[127:64];
        x4 = s[63:0];
        x2 = x2 ^ {56'd0, rinv, r};
        x0 = x0 ^ x4;
        x4 = x4 ^ x3;
        x2 = x2 ^ x1;
        t0 = ~x0 & x1;
        t1 = ~x1 & x2;
        t2 = ~x2 & x3;
        t3 = ~x3 & x4;
        t4 = ~x4 & x0;
        x0 = x0 ^ t1;
        x1 = x1 ^ t2;
        x2 = x2 ^ t3;
        x3 = x3 ^ t4;
        x4 = x4 ^ t0;
        x1 = x1 ^ x0;
        x0 = x0 ^ x4;
        x3 = x3 ^ x2;
        x2 = ~x2;
        x0 = x0 ^ ror64(x0, 19) ^ ror64(x0, 28);
        x1 = x1 ^ ror64(x1, 61) ^ ror64(x1, 39);
        x2 = x2 ^ ror64(x2, 1)  ^ ror64(x2, 6);
        x3 = x3 ^ ror64(x3, 10) ^ ror64(x3, 17);
        x4 = x4 ^ ror64(x4, 7)  ^ ror64(x4, 41);
        return {x0, x1, x2, x3, x4};
    endfunction

    // Constant index for the next round to apply.
    assign rc   = 4'd12 - cnt_q;
    assign rnd1 = round_f(state_q, rc);
`ifdef PERM_UNROLL2_EN
    assign rnd2 = round_f(rnd1, rc + 4'd1);
`endif

    assign bus.S_out = sout_q;

    // Next-state logic: capture on start when idle, then apply rounds until none remain.
    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        sout_d  = sout_q;
        cnt_d   = cnt_q;
        case (fsm_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = bus.S;
                    cnt_d   = (bus.round > 5'd12) ? 4'd12 : bus.round[3:0];
                    fsm_d   = ST_RUN;
                end
            end
            ST_RUN: begin
                if (cnt_q == 4'd0) begin
                    // Zero rounds requested: publish the captured state unchanged.
                    sout_d = state_q;
                    fsm_d  = ST_IDLE;
`ifdef PERM_UNROLL2_EN
                end else if (cnt_q == 4'd1) begin
                    state_d = rnd1;
                    sout_d  = rnd1;
                    cnt_d   = 4'd0;
                    fsm_d   = ST_IDLE;
                end else begin
                    state_d = rnd2;
                    cnt_d   = cnt_q - 4'd2;
                    if (cnt_q == 4'd2) begin
                        sout_d = rnd2;
                        fsm_d  = ST_IDLE;
                    end
                end
`else
                end else begin
                    state_d = rnd1;
                    cnt_d   = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        sout_d = rnd1;
                        fsm_d  = ST_IDLE;
                    end
                end
`endif
            end
            default: fsm_d = ST_IDLE;
        endcase
    end

    // State registers; reset clears everything and aborts a running operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q   <= ST_IDLE;
            state_q <= '0;
            sout_q  <= '0;
            cnt_q   <= '0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            sout_q  <= sout_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_permutation.sv
// Directed and randomised bench for the ASCON permutation core. The reference
// model is a per-bit-column S-box table lookup plus bitwise rotation indexing.
module tb_permutation;

    logic clk;
    logic rst;
    permutation_if bus ();

    permutation dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [4:0] sbox_tab [32] = '{
        5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
    };

    typedef struct {
        logic [319:0] s;
        logic [4:0]   rnd;
        logic [319:0] exp;
        int           lat;
        string        name;
    } vec_t;

    function automatic int neff_of(input logic [4:0] rnd);
        return (rnd > 5'd12) ? 12 : int'(rnd);
    endfunction

    function automatic int lat_of(input logic [4:0] rnd);
        int n;
        n = neff_of(rnd);
        if (n == 0) return 1;
`ifdef PERM_UNROLL2_EN
        return (n + 1) / 2;
`else
        return n;
`endif
    endfunction

    function automatic logic [319:0] ref_perm(input logic [319:0] s, input logic [4:0] rnd);
        logic [63:0] x [5];
        logic [63:0] y [5];
        logic [4:0]  v;
        int          ra [5];
        int          rb [5];
        int          n;
        int          r;
        ra = '{19, 61, 1, 10, 7};
        rb = '{28, 39, 6, 17, 41};
        n  = neff_of(rnd);
        for (int k = 0; k < 5; k++) x[k] = s[319 - 64*k -: 64];
        for (int i = 0; i < n; i++) begin
            r = 12 - n + i;
            x[2][7:0] = x[2][7:0] ^ 8'((15 - r) * 16 + r);
            for (int j = 0; j < 64; j++) begin
                v = sbox_tab[{x[0][j], x[1][j], x[2][j], x[3][j], x[4][j]}];
                y[0][j] = v[4];
                y[1][j] = v[3];
                y[2][j] = v[2];
                y[3][j] = v[1];
                y[4][j] = v[0];
            end
            for (int k = 0; k < 5; k++)
                for (int j = 0; j < 64; j++)
                    x[k][j] = y[k][j] ^ y[k][(j + ra[k]) % 64] ^ y[k][(j + rb[k]) % 64];
        end
        return {x[0], x[1], x[2], x[3], x[4]};
    endfunction

    function automatic logic [319:0] rand320();
        logic [319:0] v;
        for (int k = 0; k < 10; k++) v[32*k +: 32] = $urandom;
        return v;
    endfunction

    task automatic check(input string name, input logic [319:0] act, input logic [319:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start one operation, zero S after the start edge, check hold then result.
    task automatic run_op(input string name, input logic [319:0] s, input logic [4:0] rnd,
                          input logic [319:0] prev, input logic [319:0] exp, input int lat);
        bus.S     = s;
        bus.round = rnd;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.S     = '0;
        for (int k = 1; k <= lat; k++) begin
            tick();
            if (k < lat) check({name, "_hold"}, bus.S_out, prev);
            else         check({name, "_result"}, bus.S_out, exp);
        end
        tick();
        tick();
        check({name, "_after"}, bus.S_out, exp);
    endtask

    vec_t         vecs [8];
    logic [319:0] last;
    logic [319:0] sa, sb, sc, eb, ec;
    int           L;

    initial begin
        sa = rand320();
        vecs[0] = '{ {64'h80400c0600000000, 64'd45400375717294337, 64'd16688268966856064344,
                      64'd3724962908607778966, 64'd5511705892194216375}, 5'd6,
                     320'hdbfa7de9557bfe77cd1ee5a28bf38302ddaaba10f9bbc338f08f66dfae56028e3c3fa37c30f578a4,
                     lat_of(5'd6), "spec_p6" };
        vecs[1] = '{ '0, 5'd12, ref_perm('0, 5'd12), lat_of(5'd12), "zero_p12" };
        vecs[2] = '{ sa, 5'd0,  sa,                  lat_of(5'd0),  "round0" };
        vecs[3] = '{ sa, 5'd15, ref_perm(sa, 5'd12), lat_of(5'd15), "round15" };
        vecs[4] = '{ sa, 5'd12, ref_perm(sa, 5'd12), lat_of(5'd12), "round12" };
        vecs[5] = '{ sa, 5'd1,  ref_perm(sa, 5'd1),  lat_of(5'd1),  "round1" };
        vecs[6] = '{ sa, 5'd7,  ref_perm(sa, 5'd7),  lat_of(5'd7),  "round7" };
        vecs[7] = '{ sa, 5'd8,  ref_perm(sa, 5'd8),  lat_of(5'd8),  "round8" };

        rst       = 1'b1;
        bus.S     = '0;
        bus.round = '0;
        bus.start = 1'b0;
        tick();
        tick();
        check("reset_sout", bus.S_out, '0);
        rst = 1'b0;
        tick();
        check("reset_idle", bus.S_out, '0);
        last = '0;

        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].name, vecs[i].s, vecs[i].rnd, last, vecs[i].exp, vecs[i].lat);
            last = vecs[i].exp;
        end

        // start held high: ignored while busy and on the completion edge,
        // accepted on the first idle edge after it.
        sb = rand320();
        sc = rand320();
        eb = ref_perm(sb, 5'd3);
        ec = ref_perm(sc, 5'd3);
        L  = lat_of(5'd3);
        bus.S     = sb;
        bus.round = 5'd3;
        bus.start = 1'b1;
        tick();
        bus.S = sc;
        for (int k = 1; k <= 2 * L + 1; k++) begin
            tick();
            if (k < L)                check("held_hold1", bus.S_out, last);
            else if (k < 2 * L + 1)   check("held_first", bus.S_out, eb);
            else                      check("held_second", bus.S_out, ec);
        end
        bus.start = 1'b0;
        tick();
        tick();
        check("held_settle", bus.S_out, ec);
        last = ec;

        // Mid-operation start with a different request must not disturb the result.
        sb = rand320();
        eb = ref_perm(sb, 5'd12);
        L  = lat_of(5'd12);
        bus.S     = sb;
        bus.round = 5'd12;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int k = 1; k <= L; k++) begin
            if (k == 2) begin
                bus.S     = sc;
                bus.round = 5'd1;
                bus.start = 1'b1;
            end else begin
                bus.start = 1'b0;
            end
            tick();
            if (k < L) check("midstart_hold", bus.S_out, last);
            else       check("midstart_result", bus.S_out, eb);
        end
        bus.start = 1'b0;
        tick();
        check("midstart_after", bus.S_out, eb);
        last = eb;

        // Reset in the middle of an operation aborts it and clears the output.
        bus.S     = sa;
        bus.round = 5'd12;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_clear", bus.S_out, '0);
        for (int k = 0; k < 14; k++) tick();
        check("midrst_aborted", bus.S_out, '0);
        last = '0;
        run_op("after_rst", sa, 5'd6, last, ref_perm(sa, 5'd6), lat_of(5'd6));
        last = ref_perm(sa, 5'd6);

        for (int it = 0; it < 200; it++) begin
            logic [319:0] s;
            logic [4:0]   r;
            s = rand320();
            r = 5'($urandom_range(1, 12));
            eb = ref_perm(s, r);
            run_op("random", s, r, last, eb, lat_of(r));
            last = eb;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
